muldiv_unit: RTL

Iterative RISC-V M-extension multiply/divide unit, parametrised in datapath width. It sits beside the single-cycle ALU in the execute stage and decodes its own operation from ALUOp/Funct7/Funct3. It runs a start/busy/done handshake so the controller can stall the pipeline. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.

---
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Decodes its own op from ALUOp/Funct7/Funct3 and runs a start/busy/done
// handshake so the controller can stall the pipeline.
//   Multiply: shift-add, one multiplier bit per CALC cycle (latency WIDTH+2).
//   Divide:   restoring, one quotient bit per CALC cycle (latency WIDTH+2).
//   Divide-by-zero and signed overflow resolve at accept (latency 1).
// Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies compute the
// product at accept and go straight to FIX (latency 2).
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start             request, sampled only in IDLE or DONE
//   ALUOp/Funct7/Funct3  instruction decode fields
//   SrcA, SrcB        rs1 / rs2 operands
//   is_muldiv         combinational decode flag
//   busy              high in CALC and FIX
//   done              one-cycle result-valid pulse
//   Result            registered result, held until next accept or reset
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             is_muldiv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next, launch_state;

  // Latched operation context
  logic [2:0]       op;
  logic             a_neg, b_neg;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    acc;    // mul: {partial, multiplier}; div: low half = dividend/quotient
  logic [WIDTH:0]   rem;    // partial remainder
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor magnitude

  // Accept-time decode
  logic             accept;
  logic             sgn_a_in, sgn_b_in;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, sgn_ovf, special, fast_in;
  logic [WIDTH-1:0] special_val;

  assign is_muldiv = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign accept    = start && is_muldiv && ((state == IDLE) || (state == DONE));

  // Operand signedness per op
  always_comb begin
    sgn_a_in = 1'b0;
    sgn_b_in = 1'b0;
    unique case (Funct3)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn_a_in = 1'b1;
        sgn_b_in = 1'b1;
      end
      OP_MULHSU: sgn_a_in = 1'b1;
      OP_MULHU, OP_DIVU, OP_REMU: ;
      default: ;
    endcase
  end

  assign a_neg_in = sgn_a_in && SrcA[WIDTH-1];
  assign b_neg_in = sgn_b_in && SrcB[WIDTH-1];
  assign mag_a    = a_neg_in ? -SrcA : SrcA;
  assign mag_b    = b_neg_in ? -SrcB : SrcB;

  // Divide special cases bypass the iteration entirely
  assign div_zero = (SrcB == '0);
  assign sgn_ovf  = sgn_b_in && (SrcA == MIN_NEG) && (SrcB == '1);
  assign special  = Funct3[2] && (div_zero || sgn_ovf);

  // Funct3[1] distinguishes REM* from DIV* among divide ops
  always_comb begin
    special_val = '1;
    if (div_zero) begin
      special_val = Funct3[1] ? SrcA : '1;
    end else begin
      special_val = Funct3[1] ? '0 : SrcA;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_in = ~Funct3[2];
`else
  assign fast_in = 1'b0;
`endif

  assign launch_state = special ? DONE : (fast_in ? FIX : CALC);

  // One shift-add multiply step
  logic [WIDTH:0]  mul_sum;
  logic [DW-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step: shift in next dividend bit, trial subtract
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ok;
  assign div_shift = (WIDTH+1)'({rem, acc[WIDTH-1]});
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];

  // Sign correction and result selection
  logic             prod_neg;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem_lo, rem_fix, fix_val;
  assign prod_neg = a_neg ^ b_neg;
  assign prod     = prod_neg ? -acc : acc;
  assign quo      = prod_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_lo   = WIDTH'(rem);
  assign rem_fix  = a_neg ? -rem_lo : rem_lo;

  always_comb begin
    fix_val = prod[WIDTH-1:0];
    unique case (op)
      OP_MUL:                       fix_val = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[DW-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_val = quo;
      OP_REM, OP_REMU:              fix_val = rem_fix;
      default:                      fix_val = prod[WIDTH-1:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = launch_state;
      CALC: if (cnt == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = accept ? launch_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
      op     <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
    end else begin
      busy <= (state_next == CALC) || (state_next == FIX);
      done <= (state_next == DONE);
      if (accept) begin
        op    <= Funct3;
        a_neg <= a_neg_in;
        b_neg <= b_neg_in;
        cnt   <= '0;
        rem   <= '0;
        opnd  <= Funct3[2] ? mag_b : mag_a;
        acc   <= DW'(Funct3[2] ? mag_a : mag_b);
`ifdef MULDIV_FAST_MUL_EN
        if (fast_in) acc <= DW'(mag_a) * DW'(mag_b);
`endif
        if (special) Result <= special_val;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (op[2]) begin
          rem            <= div_ok ? div_diff : div_shift;
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
        end else begin
          acc <= mul_next;
        end
      end else if (state == FIX) begin
        Result <= fix_val;
      end
    end
  end

endmodule
